// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response bundle between requesters, arbiter and memory
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [31:0]       ic_req_addr;
    logic [DATA_W-1:0] ic_req_rdata;
    logic              dp_req_valid;
    logic              dp_req_ready;
    logic [31:0]       dp_req_addr;
    logic [3:0]        dp_req_wstrb;
    logic [DATA_W-1:0] dp_req_wdata;
    logic [DATA_W-1:0] dp_req_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic [3:0]        mem_req_wstrb;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [DATA_W-1:0] mem_req_rdata;
    logic              grant_ic;
    logic              grant_dp;

    // Arbiter view: serves the two requesters and drives the memory port.
    modport slave (
        input  ic_req_valid, ic_req_addr,
        input  dp_req_valid, dp_req_addr, dp_req_wstrb, dp_req_wdata,
        input  mem_req_ready, mem_req_rdata,
        output ic_req_ready, ic_req_rdata, dp_req_ready, dp_req_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wstrb, mem_req_wdata,
        output grant_ic, grant_dp
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        output dp_req_valid, dp_req_addr, dp_req_wstrb, dp_req_wdata,
        output mem_req_ready, mem_req_rdata,
        input  ic_req_ready, ic_req_rdata, dp_req_ready, dp_req_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wstrb, mem_req_wdata,
        input  grant_ic, grant_dp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin memory port arbiter with icache line-refill lock
module mem_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int GAP_MAX   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int GW = $clog2(GAP_MAX) + 1;

    typedef enum logic [1:0] {IDLE, IC_XFER, IC_GAP, DP_XFER} state_t;

    state_t          state, state_nxt;
    logic            last_dp, last_dp_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic            mem_fire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            last_dp  <= 1'b1;
            beat_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            last_dp  <= last_dp_nxt;
            beat_cnt <= beat_nxt;
            gap_cnt  <= gap_nxt;
        end
    end

    always_comb begin
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wstrb = '0;
        bus.mem_req_wdata = '0;
        case (state)
            IC_XFER: begin
                bus.mem_req_valid = bus.ic_req_valid;
                bus.mem_req_addr  = bus.ic_req_addr;
            end
            DP_XFER: begin
                bus.mem_req_valid = bus.dp_req_valid;
                bus.mem_req_addr  = bus.dp_req_addr;
                bus.mem_req_wstrb = bus.dp_req_wstrb;
                bus.mem_req_wdata = bus.dp_req_wdata;
            end
            default: ;
        endcase
    end

    // A ready pulse with no request outstanding is dropped here.
    assign mem_fire         = bus.mem_req_valid & bus.mem_req_ready;
    assign bus.grant_ic     = (state == IC_XFER) || (state == IC_GAP);
    assign bus.grant_dp     = (state == DP_XFER);
    assign bus.ic_req_ready = (state == IC_XFER) & mem_fire;
    assign bus.dp_req_ready = (state == DP_XFER) & mem_fire;
    assign bus.ic_req_rdata = bus.grant_ic ? bus.mem_req_rdata : '0;
    assign bus.dp_req_rdata = bus.grant_dp ? bus.mem_req_rdata : '0;

    always_comb begin
        state_nxt   = state;
        last_dp_nxt = last_dp;
        beat_nxt    = beat_cnt;
        gap_nxt     = gap_cnt;
        case (state)
            IDLE: begin
                if (bus.ic_req_valid && (!bus.dp_req_valid || last_dp))
                    state_nxt = IC_XFER;
                else if (bus.dp_req_valid)
                    state_nxt = DP_XFER;
            end
            IC_XFER: begin
                if (!bus.ic_req_valid || (mem_fire && beat_cnt == BW'(BURST_LEN - 1))) begin
                    state_nxt   = IDLE;
                    beat_nxt    = '0;
                    last_dp_nxt = 1'b0;
                end else if (mem_fire) begin
                    state_nxt = IC_GAP;
                    beat_nxt  = beat_cnt + BW'(1);
                    gap_nxt   = '0;
                end
            end
            IC_GAP: begin
                // Data port stays locked out until the line finishes or the icache goes quiet.
                if (bus.ic_req_valid) begin
                    state_nxt = IC_XFER;
                end else if (gap_cnt == GW'(GAP_MAX - 1)) begin
                    state_nxt   = IDLE;
                    beat_nxt    = '0;
                    gap_nxt     = '0;
                    last_dp_nxt = 1'b0;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            DP_XFER: begin
                if (!bus.dp_req_valid || mem_fire) begin
                    state_nxt   = IDLE;
                    last_dp_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory request port between two requesters: the instruction-cache refill port and the data port.
- The icache refills a line as a run of consecutive single-word transactions. The arbiter locks the grant to the icache for the whole line, so data traffic cannot interleave with a refill.
- Between whole transactions or bursts, the two requesters are served round-robin.
- Sits between the icache/data master and the memory model.

Parameters:
- DATA_W, 32, data word width in bits.
- BURST_LEN, 4, icache beats per line refill; grant stays with the icache until this many beats complete.
- GAP_MAX, 2, max consecutive idle cycles in IC_GAP before the burst lock is released.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ic_req_valid  in  1  icache request; held until ic_req_ready pulses
- ic_req_ready  out  1  one-cycle completion pulse to the icache
- ic_req_addr  in  32  icache word address
- ic_req_rdata  out  DATA_W  read data, valid while ic_req_ready=1
- dp_req_valid  in  1  data-port request
- dp_req_ready  out  1  completion pulse to the data port
- dp_req_addr  in  32  data-port address
- dp_req_wstrb  in  4  byte write strobes; 0 means read
- dp_req_wdata  in  DATA_W  write data
- dp_req_rdata  out  DATA_W  read data, valid while dp_req_ready=1
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory completion pulse
- mem_req_addr  out  32  memory address
- mem_req_wstrb  out  4  memory strobes
- mem_req_wdata  out  DATA_W  memory write data
- mem_req_rdata  in  DATA_W  memory read data
- grant_ic  out  1  owner is the icache (state IC_XFER or IC_GAP)
- grant_dp  out  1  owner is the data port (state DP_XFER)

Behaviour:
- Registered state:
  - state ∈ {IDLE, IC_XFER, IC_GAP, DP_XFER}
  - last_owner (0=IC, 1=DP)
  - beat_cnt, width $clog2(BURST_LEN)+1
  - gap_cnt
- Reset (async, resetn=0):
  - state=IDLE, last_owner=DP (so the icache wins the first tie), beat_cnt=0, gap_cnt=0.
  - All outputs are 0 while in reset, including mid-transfer.
- mem_* outputs are combinational muxes of the owner's signals:
  - IC_XFER: mem_req_valid=ic_req_valid, mem_req_addr=ic_req_addr, mem_req_wstrb=0, mem_req_wdata=0.
  - DP_XFER: mem_req_valid=dp_req_valid; addr, wstrb and wdata taken from dp_*.
  - IDLE and IC_GAP: all mem_* outputs are 0.
- Ready and read data are routed only to the owner:
  - owner_ready = mem_req_ready & mem_req_valid; owner_rdata = mem_req_rdata.
  - The non-owner sees ready=0 and rdata=0.
  - A mem_req_ready arriving while mem_req_valid=0 is ignored.
- IDLE:
  - Only one valid: go to that requester's XFER state next cycle.
  - Both valid: grant the requester that is not last_owner.
  - Arbitration latency: 1 cycle from valid to mem_req_valid.
- IC_XFER:
  - Beat completes (ready pulse): beat_cnt+1.
    - If beat_cnt==BURST_LEN-1: go to IDLE, beat_cnt=0, last_owner=IC.
    - Else: go to IC_GAP with gap_cnt=0.
  - ic_req_valid=0 before completion (abort): go to IDLE, beat_cnt=0, last_owner=IC.
- IC_GAP (the icache drops valid for ≥1 cycle between beats):
  - ic_req_valid=1: go to IC_XFER.
  - Else gap_cnt+1; when gap_cnt reaches GAP_MAX-1 with valid still low: go to IDLE, beat_cnt=0, last_owner=IC.
  - dp_req_valid is ignored here: the data port is never granted mid-burst.
- DP_XFER:
  - Completion: go to IDLE, last_owner=DP.
  - dp_req_valid dropped before completion: go to IDLE, last_owner=DP.
- Timing constraints:
  - Back-to-back grants pass through IDLE, so there is at least 1 idle cycle between owners.
  - A same-cycle completion and new request is handled next cycle from IDLE.
  - Ready is never forwarded in the same cycle the state changes owner.
- Memory contract: responds ≥1 cycle after valid rises and tolerates valid being withdrawn (abort) without completion.

Test Plan:
- IC only: ic_req_valid with addr 0x100, memory ready after 2 cycles with rdata 0xDEADBEEF -> mem_req_addr=0x100, then ic_req_ready=1 for 1 cycle with ic_req_rdata=0xDEADBEEF; dp_req_ready stays 0.
- Burst lock: icache refills 0x200..0x20C as 4 beats, each with a 1-cycle valid gap, while dp_req_valid is held high throughout -> grant_ic stays high for all 4 beats; dp granted only after the 4th ready, 1 cycle later via IDLE.
- Round-robin: both valid from reset -> IC first; then both valid again -> DP, then IC; DP write (wstrb=0xF, wdata=0x12345678) appears unchanged on mem_req_*.
- Gap timeout: icache completes 1 beat then drops valid for 2 cycles -> arbiter returns to IDLE, beat_cnt=0, pending dp request granted.
- Abort: DP granted, dp_req_valid drops before mem_req_ready -> mem_req_valid falls in the same cycle, state IDLE next cycle; a late mem_req_ready is not forwarded to either port.
- Async reset mid-burst (beat 2 of 4) -> all outputs 0 immediately; after release an IC request is granted as beat 0 of a new burst.
